// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with oversampled bit timing.
// The line passes through a two-flop synchroniser. The receiver checks
// parity, framing and break, and reports each frame with a one-cycle
// o_RX_DV pulse.
// Optional feature macro: UART_RX_MAJORITY_EN. When it is defined, every bit
// decision is a 2-of-3 vote over three ticks centred on mid-bit. When it is
// undefined, each bit is taken from a single mid-bit sample.

module uart_rx_param #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_reset,
    input  logic                 i_RX,
    input  logic                 sample_tick,
    output logic                 o_RX_DV,
    output logic [DATA_BITS-1:0] o_RX_Data,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_break,
    output logic                 o_busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = 4;

    // Mid-point of the start bit, counted from the falling edge.
    localparam logic [CW-1:0] MID      = CW'(OVERSAMPLE / 2 - 1);
    // Data, parity and stop bits are decided one full bit period after the previous decision.
    localparam logic [CW-1:0] BIT_DEC  = CW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
    // The vote's last sample is one tick after centre, so the start decision moves to MID+1.
    localparam logic [CW-1:0] START_DEC = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] START_V0  = CW'(OVERSAMPLE / 2 - 2);
    localparam logic [CW-1:0] BIT_V0    = CW'(OVERSAMPLE - 3);
    localparam logic [CW-1:0] BIT_V1    = CW'(OVERSAMPLE - 2);
`else
    localparam logic [CW-1:0] START_DEC = MID;
`endif
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE,
        WAIT_IDLE
    } state_t;

    state_t                 state_reg, state_next;
    logic [1:0]             sync_reg;
    logic                   rx_s;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic [IW-1:0]          idx_reg, idx_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic                   par_bit_reg, par_bit_next;
    logic                   perr_reg, perr_next;
    logic                   ferr_reg, ferr_next;
    logic                   stop_low_reg, stop_low_next;
    logic [DATA_BITS-1:0]   data_out_reg, data_out_next;
    logic                   perr_out_reg, perr_out_next;
    logic                   ferr_out_reg, ferr_out_next;
    logic                   brk_out_reg, brk_out_next;

    logic [CW-1:0]          dec_cnt;
    logic                   at_dec;
    logic                   bit_val;

    assign rx_s = sync_reg[1];

    // Two-flop synchroniser for the asynchronous serial line; it resets to the idle level.
    always_ff @(posedge i_Clock or negedge i_reset) begin
        if (!i_reset) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], i_RX};
        end
    end

    assign dec_cnt = (state_reg == START) ? START_DEC : BIT_DEC;
    assign at_dec  = sample_tick && (cnt_reg == dec_cnt);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0]    vote_reg;
    logic [CW-1:0] v0_cnt;
    logic [CW-1:0] v1_cnt;

    assign v0_cnt = (state_reg == START) ? START_V0 : BIT_V0;
    assign v1_cnt = (state_reg == START) ? MID      : BIT_V1;

    // Capture the two early votes; the third vote is the live sample on the decision tick.
    always_ff @(posedge i_Clock or negedge i_reset) begin
        if (!i_reset) begin
            vote_reg <= 2'b11;
        end else if (sample_tick) begin
            if (cnt_reg == v0_cnt) vote_reg[0] <= rx_s;
            if (cnt_reg == v1_cnt) vote_reg[1] <= rx_s;
        end
    end

    assign bit_val = (vote_reg[0] & vote_reg[1]) |
                     (vote_reg[0] & rx_s) |
                     (vote_reg[1] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    // State and datapath registers; an asynchronous reset abandons any frame in progress.
    always_ff @(posedge i_Clock or negedge i_reset) begin
        if (!i_reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            shift_reg    <= '0;
            par_bit_reg  <= 1'b0;
            perr_reg     <= 1'b0;
            ferr_reg     <= 1'b0;
            stop_low_reg <= 1'b0;
            data_out_reg <= '0;
            perr_out_reg <= 1'b0;
            ferr_out_reg <= 1'b0;
            brk_out_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            idx_reg      <= idx_next;
            shift_reg    <= shift_next;
            par_bit_reg  <= par_bit_next;
            perr_reg     <= perr_next;
            ferr_reg     <= ferr_next;
            stop_low_reg <= stop_low_next;
            data_out_reg <= data_out_next;
            perr_out_reg <= perr_out_next;
            ferr_out_reg <= ferr_out_next;
            brk_out_reg  <= brk_out_next;
        end
    end

    // Next-state logic: tick counting, bit decisions, error accumulation and result capture.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        idx_next      = idx_reg;
        shift_next    = shift_reg;
        par_bit_next  = par_bit_reg;
        perr_next     = perr_reg;
        ferr_next     = ferr_reg;
        stop_low_next = stop_low_reg;
        data_out_next = data_out_reg;
        perr_out_next = perr_out_reg;
        ferr_out_next = ferr_out_reg;
        brk_out_next  = brk_out_reg;

        // The bit-timing counter runs only on oversample ticks and restarts at each decision.
        if ((state_reg == START || state_reg == DATA ||
             state_reg == PARITY || state_reg == STOP) && sample_tick) begin
            cnt_next = at_dec ? '0 : cnt_reg + CW'(1);
        end

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = START;
                end
            end

            START: begin
                if (at_dec) begin
                    if (!bit_val) begin
                        state_next    = DATA;
                        idx_next      = '0;
                        perr_next     = 1'b0;
                        ferr_next     = 1'b0;
                        stop_low_next = 1'b1;
                    end else begin
                        // Line high again at mid-bit: treat it as a glitch and keep the old results.
                        state_next = IDLE;
                    end
                end
            end

            DATA: begin
                if (at_dec) begin
                    shift_next = {bit_val, shift_reg[DATA_BITS-1:1]};
                    if (idx_reg == LAST_DATA) begin
                        idx_next   = '0;
                        state_next = (PARITY_MODE != 0) ? PARITY : STOP;
                    end else begin
                        idx_next = idx_reg + IW'(1);
                    end
                end
            end

            PARITY: begin
                if (at_dec) begin
                    par_bit_next = bit_val;
                    // Even mode requires a zero XOR over data and parity; odd mode requires a one.
                    if (PARITY_MODE == 2) begin
                        perr_next = ~(^shift_reg ^ bit_val);
                    end else begin
                        perr_next = ^shift_reg ^ bit_val;
                    end
                    idx_next   = '0;
                    state_next = STOP;
                end
            end

            STOP: begin
                if (at_dec) begin
                    if (!bit_val) begin
                        ferr_next = 1'b1;
                    end else begin
                        stop_low_next = 1'b0;
                    end
                    if (idx_reg == LAST_STOP) begin
                        // Results are captured on entry to DONE so they are valid alongside o_RX_DV.
                        state_next    = DONE;
                        data_out_next = shift_reg;
                        perr_out_next = perr_reg;
                        ferr_out_next = ferr_reg | ~bit_val;
                        brk_out_next  = (shift_reg == '0) &&
                                        ((PARITY_MODE == 0) || !par_bit_reg) &&
                                        stop_low_reg && !bit_val;
                    end else begin
                        idx_next = idx_reg + IW'(1);
                    end
                end
            end

            DONE: begin
                state_next = brk_out_reg ? WAIT_IDLE : IDLE;
            end

            WAIT_IDLE: begin
                // A held-low line must not be taken as a new start bit.
                if (rx_s) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_RX_DV      = (state_reg == DONE);
    assign o_RX_Data    = data_out_reg;
    assign o_parity_err = perr_out_reg;
    assign o_frame_err  = ferr_out_reg;
    assign o_break      = brk_out_reg;
    assign o_busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param. Three instances are built: 8N1 (default),
// 7E1 and 8N2. Every expected frame is pushed to a scoreboard when it is
// driven, and is popped and compared when o_RX_DV fires. Build with
// +define+UART_RX_MAJORITY_EN to add the vote-rejection case.

module tb_uart_rx_param;

    localparam int OS = 16;

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       sample_tick = 1'b0;
    logic [1:0] tick_div = 2'd0;
    logic [2:0] rx;

    logic       dv0, perr0, ferr0, brk0, busy0;
    logic [7:0] data0;
    logic       dv1, perr1, ferr1, brk1, busy1;
    logic [6:0] data1;
    logic       dv2, perr2, ferr2, brk2, busy2;
    logic [7:0] data2;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   dv_cnt[3];
    int   exp_dv[3];

    uart_rx_param u_8n1 (
        .i_Clock(clk), .i_reset(rst_n), .i_RX(rx[0]), .sample_tick(sample_tick),
        .o_RX_DV(dv0), .o_RX_Data(data0), .o_parity_err(perr0),
        .o_frame_err(ferr0), .o_break(brk0), .o_busy(busy0)
    );

    uart_rx_param #(.DATA_BITS(7), .PARITY_MODE(1)) u_7e1 (
        .i_Clock(clk), .i_reset(rst_n), .i_RX(rx[1]), .sample_tick(sample_tick),
        .o_RX_DV(dv1), .o_RX_Data(data1), .o_parity_err(perr1),
        .o_frame_err(ferr1), .o_break(brk1), .o_busy(busy1)
    );

    uart_rx_param #(.STOP_BITS(2)) u_8n2 (
        .i_Clock(clk), .i_reset(rst_n), .i_RX(rx[2]), .sample_tick(sample_tick),
        .o_RX_DV(dv2), .o_RX_Data(data2), .o_parity_err(perr2),
        .o_frame_err(ferr2), .o_break(brk2), .o_busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One oversample tick every 4 clocks, changed on the falling edge so it is stable at posedge.
    always @(negedge clk) begin
        tick_div    <= tick_div + 2'd1;
        sample_tick <= (tick_div == 2'd3);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int k, input logic [8:0] d, input logic p, input logic f, input logic b);
        exp_t e;
        e.inst = k; e.data = d; e.perr = p; e.ferr = f; e.brk = b;
        sb.push_back(e);
        exp_dv[k]++;
    endtask

    // Pop the oldest expected frame and compare it with the frame the DUT just reported.
    task automatic take(input int k, input logic [8:0] d, input logic p, input logic f, input logic b);
        exp_t e;
        dv_cnt[k]++;
        $display("RX inst%0d data=%0h perr=%0b ferr=%0b brk=%0b", k, d, p, f, b);
        check("dv_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("dv_inst",  32'(k), 32'(e.inst));
            check("rx_data",  32'(d), 32'(e.data));
            check("perr",     32'(p), 32'(e.perr));
            check("ferr",     32'(f), 32'(e.ferr));
            check("brk",      32'(b), 32'(e.brk));
        end
    endtask

    // Monitor: sample the DV strobes away from the active edge.
    always @(negedge clk) begin
        if (dv0) take(0, {1'b0, data0}, perr0, ferr0, brk0);
        if (dv1) take(1, {2'b0, data1}, perr1, ferr1, brk1);
        if (dv2) take(2, {1'b0, data2}, perr2, ferr2, brk2);
    end

    // Wait for n ticks, then step just past the tick edge.
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!sample_tick) @(posedge clk);
        end
        #1;
    endtask

    // Drive nbits of a frame LSB first, each held for one bit period.
    task automatic send_bits(input int k, input logic [15:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            rx[k] = frame[i];
            wait_ticks(OS);
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_pending"}, 32'(sb.size()), 32'd0);
        for (int k = 0; k < 3; k++) begin
            check({tag, "_dvcnt"}, 32'(dv_cnt[k]), 32'(exp_dv[k]));
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            dv_cnt[k] = 0;
            exp_dv[k] = 0;
        end
        rx    = 3'b111;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_dv",   32'(dv0),   32'd0);
        check("rst_data", 32'(data0), 32'd0);
        check("rst_flags", 32'({perr0, ferr0, brk0}), 32'd0);
        check("rst_busy", 32'({busy0, busy1, busy2}), 32'd0);
        rst_n = 1'b1;
        wait_ticks(2);

        // Back-to-back 8N1 frames.
        push(0, 9'h055, 1'b0, 1'b0, 1'b0);
        push(0, 9'h0A3, 1'b0, 1'b0, 1'b0);
        send_bits(0, {1'b1, 8'h55, 1'b0}, 10);
        send_bits(0, {1'b1, 8'hA3, 1'b0}, 10);
        wait_ticks(4);
        check_counts("8n1");
        check("hold_data", 32'(data0), 32'hA3);
        check("idle_busy", 32'(busy0), 32'd0);

        // Reset during data bit 3 of 0xA5 (start, 1, 0, 1 already sent; bit 3 is 0).
        send_bits(0, 16'b1010, 4);
        rx[0] = 1'b0;
        wait_ticks(8);
        check("busy_midframe", 32'(busy0), 32'd1);
        rst_n = 1'b0;
        rx[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_data", 32'(data0), 32'd0);
        check("midrst_busy", 32'(busy0), 32'd0);
        rst_n = 1'b1;
        wait_ticks(20);
        check("midrst_dv", 32'(dv_cnt[0]), 32'(exp_dv[0]));
        push(0, 9'h03C, 1'b0, 1'b0, 1'b0);
        send_bits(0, {1'b1, 8'h3C, 1'b0}, 10);
        wait_ticks(4);
        check_counts("after_rst");

        // 7E1 parity: 0x41 has two ones, so even parity is 0.
        push(1, 9'h041, 1'b0, 1'b0, 1'b0);
        send_bits(1, {1'b1, 1'b0, 7'h41, 1'b0}, 10);
        push(1, 9'h041, 1'b1, 1'b0, 1'b0);
        send_bits(1, {1'b1, 1'b1, 7'h41, 1'b0}, 10);
        push(1, 9'h007, 1'b0, 1'b0, 1'b0);
        send_bits(1, {1'b1, 1'b1, 7'h07, 1'b0}, 10);
        wait_ticks(4);
        check_counts("7e1");

        // 8N2: a clean frame, then one whose second stop bit is low. That stop bit is
        // shortened to 12 ticks so the receiver's re-armed start check sees the line high.
        push(2, 9'h07E, 1'b0, 1'b0, 1'b0);
        send_bits(2, {1'b1, 1'b1, 8'h7E, 1'b0}, 11);
        push(2, 9'h07E, 1'b0, 1'b1, 1'b0);
        send_bits(2, {1'b1, 8'h7E, 1'b0}, 10);
        rx[2] = 1'b0;
        wait_ticks(12);
        rx[2] = 1'b1;
        wait_ticks(24);
        check_counts("8n2");
        check("8n2_busy", 32'(busy2), 32'd0);

        // Break: the line is held low for three frame times.
        push(0, 9'h000, 1'b0, 1'b1, 1'b1);
        rx[0] = 1'b0;
        wait_ticks(3 * 10 * OS);
        check("brk_wait_busy", 32'(busy0), 32'd1);
        check_counts("brk");
        rx[0] = 1'b1;
        wait_ticks(8);
        check("brk_released", 32'(busy0), 32'd0);
        check("brk_hold", 32'({brk0, ferr0}), 32'b11);

        // A 3-tick glitch enters START and is then rejected as a false start.
        rx[0] = 1'b0;
        wait_ticks(3);
        rx[0] = 1'b1;
        wait_ticks(4);
        check("glitch_start", 32'(busy0), 32'd1);
        wait_ticks(10);
        check("glitch_idle", 32'(busy0), 32'd0);
        check("glitch_flags", 32'({brk0, ferr0}), 32'b11);
        check_counts("glitch");

`ifdef UART_RX_MAJORITY_EN
        // A 1-tick inverted spike on the centre vote of data bit 0 of 0x01 is outvoted.
        push(0, 9'h001, 1'b0, 1'b0, 1'b0);
        send_bits(0, 16'b0, 1);
        rx[0] = 1'b1;
        wait_ticks(7);
        rx[0] = 1'b0;
        wait_ticks(1);
        rx[0] = 1'b1;
        wait_ticks(8);
        send_bits(0, {1'b1, 7'h00}, 8);
        wait_ticks(4);
        check_counts("majority");
`endif

        // A normal frame after the break clears the held flags.
        push(0, 9'h0C3, 1'b0, 1'b0, 1'b0);
        send_bits(0, {1'b1, 8'hC3, 1'b0}, 10);
        wait_ticks(4);
        check_counts("final");
        check("final_flags", 32'({brk0, ferr0, perr0}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
